gpr_regfile_sb: RTL and testbench
=================================

// Module: gpr_regfile_sb
// PURPOSE
// - Parametrised general-purpose register file for the MIPS datapath: 2 async read ports, 1 sync write port.
// - Adds a per-register pending scoreboard so decode can stall on load-use hazards without extra logic.
// - Sits between decode (reads, marks) and writeback (writes). It is the next-generation replacement for the fixed 32x32 GPR.
// PARAMETERS
// - DATA_W    32  register width in bits
// - ADDR_W    5   address width; depth = 2**ADDR_W registers
// - ZERO_REG  1   1: register 0 reads 0, ignores writes and marks; 0: register 0 is ordinary
// PORTS
// - clk        in   1         clock, all state updates on posedge only
// - rst        in   1         reset, asynchronous, active-high
// - we         in   1         write enable (writeback stage)
// - waddr      in   ADDR_W    write address
// - wdata      in   DATA_W    write data
// - raddr_a    in   ADDR_W    read port A address
// - raddr_b    in   ADDR_W    read port B address
// - rdata_a    out  DATA_W    read port A data (combinational)
// - rdata_b    out  DATA_W    read port B data (combinational)
// - mark_en    in   1         set pending bit of mark_addr (long-latency producer issued)
// - mark_addr  in   ADDR_W    register to mark pending
// - flush      in   1         clear all pending bits (pipeline squash)
// - busy_a     out  1         pending bit of raddr_a (combinational)
// - busy_b     out  1         pending bit of raddr_b (combinational)
// - pend_cnt   out  ADDR_W+1  number of registers currently pending
// BEHAVIOUR
// - Reset (async, any time): all registers <= 0, all pending bits <= 0, pend_cnt <= 0. Reads return 0 while rst is high.
// - Write: on posedge clk with we=1, reg[waddr] <= wdata and pending[waddr] <= 0. There is a single clock edge. No negedge writes.
// - ZERO_REG=1: writes and marks to address 0 are dropped. rdata of address 0 is always 0. busy for address 0 is always 0.
// - Reads are combinational from the array, with bypass per CONFIGURATION.
// - busy_x = pending[raddr_x]. With bypass enabled, busy_x = 0 when we=1 and waddr==raddr_x in the same cycle.
// - Mark: on posedge with mark_en=1, pending[mark_addr] <= 1.
// - Precedence per address, same edge, highest first:
//   1. flush: all pending <= 0. Marks are dropped. Writes still update data.
//   2. mark: a mark and a write to the same address leave pending=1, because the new producer supersedes.
//   3. write: clears the pending bit.
// - pend_cnt is the registered popcount of pending and always equals the number of set bits after every edge.
// - pend_cnt is maintained incrementally: +1 on a mark of a non-pending address, -1 on a write that clears a set bit.
// - When a mark and a write hit different addresses on the same edge, the increment and decrement net out.
// - Marking an already-pending register leaves pend_cnt unchanged. A write to a non-pending register leaves pend_cnt unchanged.
// - pend_cnt max = 2**ADDR_W (minus 1 if ZERO_REG). It saturates there and never wraps.
// - Latency: write visible on rdata at the first read after the edge, or the same cycle with bypass. Mark/clear visible on busy after the edge.
// CONFIGURATION
// - Macro GPR_BYPASS_EN.
// - Defined: write-through forwarding. If we=1 and waddr==raddr_x (and not address 0 under ZERO_REG), rdata_x = wdata combinationally and busy_x = 0.
// - Not defined: rdata_x returns the stored value until the write edge, and busy_x reflects the stored pending bit.
// TESTING
// - Reset: write 0xDEADBEEF to r5, pulse rst mid-cycle -> rdata(r5)=0 immediately, pend_cnt=0, busy=0.
// - Zero reg: we=1 waddr=0 wdata=0x1234, mark_addr=0 -> rdata(r0)=0, busy=0, pend_cnt=0.
// - Scoreboard: mark r3, then r7, then r3 again -> pend_cnt 1,2,2. Write r3=0x55 -> busy(r3)=0, pend_cnt=1, rdata=0x55.
// - Collision: mark r4 and write r4=0xAA on the same edge -> reg r4=0xAA, busy(r4)=1, pend_cnt+1. Mark r2 with write r9 pending -> pend_cnt unchanged.
// - Flush: mark r1,r2,r3, then flush with mark r8 and write r2=0x77 on the same edge -> pend_cnt=0, busy(r8)=0, r2=0x77.
// - Bypass: r6=0x10 stored, drive we=1 waddr=6 wdata=0x20, raddr_a=6 -> with GPR_BYPASS_EN rdata_a=0x20 same cycle, otherwise 0x10, then 0x20 after the edge.

Source files
------------

// File: rtl/gpr_regfile_sb.sv
// GPR file (2 async read, 1 sync write) with per-register pending scoreboard and pend_cnt.
// Latency: reads combinational, write/mark/flush take effect at posedge (same-cycle data with bypass).
// Backpressure: none; decode stalls itself on busy_a/busy_b. Optional macro: GPR_BYPASS_EN (write-through forwarding).
module gpr_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              flush,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  // Highest reachable count; r0 can never be pending when it is hardwired.
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH - ((ZERO_REG != 0) ? 1 : 0));

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_ok;
  logic              mark_ok;
  logic              cnt_inc;
  logic              cnt_dec;

  // Qualify write and mark: address 0 is inert when hardwired to zero.
  always_comb begin
    wr_ok   = we      && !((ZERO_REG != 0) && (waddr == '0));
    mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));
  end

  // Incremental count deltas: a mark only counts if the bit was clear, a write
  // only counts if it actually clears a set bit (not re-marked on the same edge).
  always_comb begin
    cnt_inc = mark_ok && !pending[mark_addr];
    cnt_dec = wr_ok && pending[waddr] && !(mark_ok && (mark_addr == waddr));
  end

  // Data array: single posedge write port, whole array cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Pending bits: flush beats mark beats write; the later NBA gives mark priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      if (wr_ok)   pending[waddr]     <= 1'b0;
      if (mark_ok) pending[mark_addr] <= 1'b1;
    end
  end

  // Pending counter tracks popcount(pending) without an adder tree; saturates at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt <= '0;
    end else if (flush) begin
      pend_cnt <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      if (pend_cnt != CNT_MAX) pend_cnt <= pend_cnt + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      if (pend_cnt != '0) pend_cnt <= pend_cnt - 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = mem[a];
`ifdef GPR_BYPASS_EN
    if (wr_ok && (waddr == a)) d = wdata;
`endif
    if (rst || ((ZERO_REG != 0) && (a == '0))) d = '0;
    return d;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = pending[a];
`ifdef GPR_BYPASS_EN
    if (wr_ok && (waddr == a)) b = 1'b0;
`endif
    if (rst || ((ZERO_REG != 0) && (a == '0))) b = 1'b0;
    return b;
  endfunction

  // Combinational read ports with optional write-through forwarding.
  always_comb begin
    rdata_a = rd_data(raddr_a);
    rdata_b = rd_data(raddr_b);
    busy_a  = rd_busy(raddr_a);
    busy_b  = rd_busy(raddr_b);
  end

endmodule

// File: tb/tb_gpr_regfile_sb.sv
// Bench for gpr_regfile_sb: directed scenarios followed by random traffic.
// Expected outputs come from an array/bit-vector model and are queued per cycle.
// A negedge monitor pops each entry and compares it with the DUT outputs.
module tb_gpr_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] raddr_a = '0;
  logic [AW-1:0] raddr_b = '0;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          mark_en = 1'b0;
  logic [AW-1:0] mark_addr = '0;
  logic          flush = 1'b0;
  logic          busy_a;
  logic          busy_b;
  logic [AW:0]   pend_cnt;

  gpr_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mark_en(mark_en), .mark_addr(mark_addr), .flush(flush),
    .busy_a(busy_a), .busy_b(busy_b), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic          ba;
    logic          bb;
    logic [AW:0]   cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference state
  logic [DW-1:0] m_mem [DEPTH];
  bit   [DEPTH-1:0] m_pend;

  task automatic check(input string nm, input string fld, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, "rdata_a", rdata_a, e.ra);
      check(n, "rdata_b", rdata_b, e.rb);
      check(n, "busy_a", {31'd0, busy_a}, {31'd0, e.bb ? e.ba : e.ba});
      check(n, "busy_b", {31'd0, busy_b}, {31'd0, e.bb});
      check(n, "pend_cnt", {26'd0, pend_cnt}, {26'd0, e.cnt});
    end
  end

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_rd(bit r, bit w, int wa, logic [DW-1:0] wd, int a);
    if (r || a == 0) return '0;
`ifdef GPR_BYPASS_EN
    if (w && wa == a) return wd;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(bit r, bit w, int wa, int a);
    if (r || a == 0) return 1'b0;
`ifdef GPR_BYPASS_EN
    if (w && wa == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  // One clock of stimulus: drive, queue expected pre-edge outputs, step the model.
  task automatic cycle(input string nm, input bit r, input bit w, input int wa, input logic [DW-1:0] wd,
                       input int ra, input int rb, input bit m, input int ma, input bit f);
    exp_t e;
    rst = r; we = w; waddr = AW'(wa); wdata = wd;
    raddr_a = AW'(ra); raddr_b = AW'(rb);
    mark_en = m; mark_addr = AW'(ma); flush = f;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_pend = '0;
    end
    e.ra  = exp_rd(r, w, wa, wd, ra);
    e.rb  = exp_rd(r, w, wa, wd, rb);
    e.ba  = exp_busy(r, w, wa, ra);
    e.bb  = exp_busy(r, w, wa, rb);
    e.cnt = (AW+1)'(popcount());
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (!r) begin
      if (w && wa != 0) begin
        m_mem[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (m && ma != 0) m_pend[ma] = 1'b1;
      if (f) m_pend = '0;
    end
  endtask

  task automatic idle(input string nm, input int ra, input int rb);
    cycle(nm, 0, 0, 0, '0, ra, rb, 0, 0, 0);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_pend = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle("rst_state", 1, 0, 0, '0, 5, 9, 0, 0, 0);
    // Reset in the middle of activity
    cycle("wr_r5", 0, 1, 5, 32'hDEADBEEF, 5, 9, 1, 9, 0);
    idle("rd_r5", 5, 9);
    cycle("rst_pulse", 1, 0, 0, '0, 5, 9, 0, 0, 0);
    idle("post_rst", 5, 9);
    // Hardwired zero register
    cycle("zero_wr", 0, 1, 0, 32'h1234, 0, 0, 1, 0, 0);
    idle("zero_rd", 0, 0);
    // Scoreboard counting
    cycle("mk3", 0, 0, 0, '0, 3, 7, 1, 3, 0);
    cycle("mk7", 0, 0, 0, '0, 3, 7, 1, 7, 0);
    cycle("mk3_again", 0, 0, 0, '0, 3, 7, 1, 3, 0);
    cycle("wr3", 0, 1, 3, 32'h55, 3, 7, 0, 0, 0);
    idle("after_wr3", 3, 7);
    // Mark/write collisions
    cycle("col4", 0, 1, 4, 32'hAA, 4, 7, 1, 4, 0);
    idle("col4_chk", 4, 7);
    cycle("mk9", 0, 0, 0, '0, 2, 9, 1, 9, 0);
    cycle("mk2_wr9", 0, 1, 9, 32'h99, 2, 9, 1, 2, 0);
    idle("mk2_wr9_chk", 2, 9);
    // Flush with simultaneous mark and write
    cycle("mk1", 0, 0, 0, '0, 1, 8, 1, 1, 0);
    cycle("mk2", 0, 0, 0, '0, 1, 8, 1, 2, 0);
    cycle("mk3f", 0, 0, 0, '0, 2, 8, 1, 3, 0);
    cycle("flush", 0, 1, 2, 32'h77, 2, 8, 1, 8, 1);
    idle("flush_chk", 2, 8);
    // Write-through forwarding
    cycle("wr6", 0, 1, 6, 32'h10, 6, 6, 0, 0, 0);
    cycle("byp6", 0, 1, 6, 32'h20, 6, 5, 0, 0, 0);
    idle("byp6_chk", 6, 5);
    // Saturation: every register pending, then re-marks
    for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 0, 0, '0, i, 31, 1, i, 0);
    cycle("remark", 0, 0, 0, '0, 5, 31, 1, 5, 0);
    idle("sat_chk", 5, 0);
    cycle("sat_flush", 0, 0, 0, '0, 5, 0, 0, 0, 1);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit w, m, f, r;
      int wa, ra, rb, ma;
      w  = ($urandom_range(0, 1) == 1);
      m  = ($urandom_range(0, 9) < 4);
      f  = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 499) == 0);
      wa = $urandom_range(0, DEPTH-1);
      ma = ($urandom_range(0, 5) == 0) ? wa : $urandom_range(0, DEPTH-1);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH-1);
      rb = ($urandom_range(0, 3) == 0) ? ma : $urandom_range(0, DEPTH-1);
      cycle("rand", r, w, wa, $urandom, ra, rb, m, ma, f);
    end
    idle("final", 1, 2);
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
